// File: rtl/gpr_wr_arbiter.sv
// Register-file write-port arbiter: two writeback sources, each with a small FIFO,
// drained round-robin into a registered single write port.
module gpr_wr_arbiter #(
  parameter int DEPTH = 4,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [4:0]    req0_addr,
  input  logic [DW-1:0] req0_data,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [4:0]    req1_addr,
  input  logic [DW-1:0] req1_data,
  output logic          rw,
  output logic [4:0]    WriteReg,
  output logic [DW-1:0] WriteData,
  output logic [31:0]   pend_mask,
  output logic          idle
);

  localparam int AW = $clog2(DEPTH);

  logic [4:0]    addr0_mem [DEPTH];
  logic [DW-1:0] data0_mem [DEPTH];
  logic [4:0]    addr1_mem [DEPTH];
  logic [DW-1:0] data1_mem [DEPTH];

  logic [AW:0] wr0, rd0, wr1, rd1;
  logic        empty0, empty1, full0, full1;
  logic        push0, push1, grant0, grant1;
  logic        last1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty0 = (wr0 == rd0);
  assign empty1 = (wr1 == rd1);
  assign full0  = (wr0[AW] != rd0[AW]) && (wr0[AW-1:0] == rd0[AW-1:0]);
  assign full1  = (wr1[AW] != rd1[AW]) && (wr1[AW-1:0] == rd1[AW-1:0]);

  assign req0_ready = !full0 && !rst;
  assign req1_ready = !full1 && !rst;

  // Writes to r0 complete the handshake but are dropped here.
  assign push0 = req0_valid && req0_ready && (req0_addr != 5'd0);
  assign push1 = req1_valid && req1_ready && (req1_addr != 5'd0);

  assign grant1 = !empty1 && (empty0 || !last1);
  assign grant0 = !empty0 && !grant1;

  assign idle = empty0 && empty1 && !rw;

  always_ff @(posedge clk) begin
    if (push0) begin
      addr0_mem[wr0[AW-1:0]] <= req0_addr;
      data0_mem[wr0[AW-1:0]] <= req0_data;
    end
    if (push1) begin
      addr1_mem[wr1[AW-1:0]] <= req1_addr;
      data1_mem[wr1[AW-1:0]] <= req1_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr0       <= '0;
      rd0       <= '0;
      wr1       <= '0;
      rd1       <= '0;
      last1     <= 1'b1;
      rw        <= 1'b0;
      WriteReg  <= 5'd0;
      WriteData <= '0;
    end else begin
      if (push0) wr0 <= wr0 + 1'b1;
      if (push1) wr1 <= wr1 + 1'b1;
      if (grant0) begin
        rd0       <= rd0 + 1'b1;
        last1     <= 1'b0;
        rw        <= 1'b1;
        WriteReg  <= addr0_mem[rd0[AW-1:0]];
        WriteData <= data0_mem[rd0[AW-1:0]];
      end else if (grant1) begin
        rd1       <= rd1 + 1'b1;
        last1     <= 1'b1;
        rw        <= 1'b1;
        WriteReg  <= addr1_mem[rd1[AW-1:0]];
        WriteData <= data1_mem[rd1[AW-1:0]];
      end else begin
        rw <= 1'b0;
      end
    end
  end

  // A slot is live when its distance from the read pointer is below the fill count.
  function automatic logic slot_live(input int i, input logic [AW:0] wp, input logic [AW:0] rp);
    logic [AW-1:0] off;
    off = AW'(i) - rp[AW-1:0];
    return {1'b0, off} < (wp - rp);
  endfunction

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_live(i, wr0, rd0)) pend_mask[addr0_mem[i]] = 1'b1;
      if (slot_live(i, wr1, rd1)) pend_mask[addr1_mem[i]] = 1'b1;
    end
    if (rw) pend_mask[WriteReg] = 1'b1;
    pend_mask[0] = 1'b0;
  end

endmodule

// File: tb/tb_gpr_wr_arbiter.sv
// Testbench for gpr_wr_arbiter: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_gpr_wr_arbiter;

  localparam int DEPTH = 4;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_ready, req1_ready;
  logic [4:0]    req0_addr = '0, req1_addr = '0;
  logic [DW-1:0] req0_data = '0, req1_data = '0;
  logic          rw;
  logic [4:0]    WriteReg;
  logic [DW-1:0] WriteData;
  logic [31:0]   pend_mask;
  logic          idle;

  gpr_wr_arbiter #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
    .rw(rw), .WriteReg(WriteReg), .WriteData(WriteData), .pend_mask(pend_mask), .idle(idle)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]    addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct {
    int         cyc;
    logic [4:0] r;
    logic [31:0] d;
  } log_t;

  // Reference model: two plain queues and the identity of the last winner.
  wr_t           q0[$], q1[$];
  wr_t           m_head;
  logic          m_last1 = 1'b1;
  logic          m_rw = 1'b0;
  logic [4:0]    m_reg = '0;
  logic [DW-1:0] m_data = '0;
  int            m_src = 0;
  logic          m_acc0 = 1'b0, m_acc1 = 1'b0;
  logic          model_on = 1'b0;
  int            cyc = 0;

  log_t wlog[$];
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      q0.delete();
      q1.delete();
      m_last1 = 1'b1;
      m_rw    = 1'b0;
      m_reg   = '0;
      m_data  = '0;
      m_acc0  = 1'b0;
      m_acc1  = 1'b0;
      model_on = 1'b1;
    end else begin
      m_acc0 = req0_valid && (q0.size() < DEPTH);
      m_acc1 = req1_valid && (q1.size() < DEPTH);
      if (q0.size() != 0 && (q1.size() == 0 || m_last1)) begin
        m_head = q0.pop_front();
        m_last1 = 1'b0; m_src = 0;
        m_rw = 1'b1; m_reg = m_head.addr; m_data = m_head.data;
      end else if (q1.size() != 0) begin
        m_head = q1.pop_front();
        m_last1 = 1'b1; m_src = 1;
        m_rw = 1'b1; m_reg = m_head.addr; m_data = m_head.data;
      end else begin
        m_rw = 1'b0;
      end
      if (m_acc0 && req0_addr != 5'd0) q0.push_back({req0_addr, req0_data});
      if (m_acc1 && req1_addr != 5'd0) q1.push_back({req1_addr, req1_data});
    end
  end

  function automatic logic [31:0] modelPend();
    logic [31:0] p;
    p = '0;
    foreach (q0[i]) p[q0[i].addr] = 1'b1;
    foreach (q1[i]) p[q1[i].addr] = 1'b1;
    if (m_rw) p[m_reg] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction

  function automatic logic pendFrom(input int src, input logic [4:0] a);
    logic hit;
    hit = 1'b0;
    if (src == 0) begin
      foreach (q0[i]) if (q0[i].addr == a) hit = 1'b1;
    end else begin
      foreach (q1[i]) if (q1[i].addr == a) hit = 1'b1;
    end
    if (m_rw && m_src == src && m_reg == a) hit = 1'b1;
    return hit;
  endfunction

  // Random destination that never collides with a write still pending from the other source.
  function automatic logic [4:0] pickAddr(input int src, input logic other_v, input logic [4:0] other_a);
    logic [4:0] a;
    for (int t = 0; t < 8; t++) begin
      a = 5'($urandom_range(0, 31));
      if (a == 5'd0) return a;
      if (!(other_v && other_a == a) && !pendFrom(1 - src, a)) return a;
    end
    return 5'd0;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic compareModel();
    log_t e;
    if (!model_on) return;
    checkOutput("req0_ready", 64'(req0_ready), 64'(!rst && q0.size() < DEPTH));
    checkOutput("req1_ready", 64'(req1_ready), 64'(!rst && q1.size() < DEPTH));
    checkOutput("rw", 64'(rw), 64'(m_rw));
    checkOutput("WriteReg", 64'(WriteReg), 64'(m_reg));
    checkOutput("WriteData", 64'(WriteData), 64'(m_data));
    checkOutput("pend_mask", 64'(pend_mask), 64'(modelPend()));
    checkOutput("idle", 64'(idle), 64'(q0.size() == 0 && q1.size() == 0 && !m_rw));
    if (rw === 1'b1) begin
      e.cyc = cyc; e.r = WriteReg; e.d = WriteData;
      wlog.push_back(e);
    end
  endtask

  // One clock: compare on the falling edge, return 1ns after the rising edge.
  task automatic tick();
    @(negedge clk);
    compareModel();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                               input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                               input logic r);
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    rst = r;
    tick();
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
  endtask

  initial begin
    int exp_regs[8];
    int n0, n1, c0, c1, n_enq;
    logic saw_full;
    logic v0, v1;
    logic [4:0] a0, a1;
    logic [31:0] d0, d1;

    exp_regs = '{1, 11, 2, 12, 3, 13, 4, 14};

    $display("[TB] reset state");
    doReset();
    checkOutput("rst_rw", 64'(rw), 64'd0);
    checkOutput("rst_idle", 64'(idle), 64'd1);
    checkOutput("rst_pend", 64'(pend_mask), 64'd0);
    checkOutput("rst_wreg", 64'(WriteReg), 64'd0);

    $display("[TB] single write");
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0);
    req0_valid = 1'b0;
    checkOutput("single_k_rw", 64'(rw), 64'd0);
    checkOutput("single_k_pend5", 64'(pend_mask[5]), 64'd1);
    tick();
    checkOutput("single_k1_rw", 64'(rw), 64'd1);
    checkOutput("single_k1_reg", 64'(WriteReg), 64'd5);
    checkOutput("single_k1_data", 64'(WriteData), 64'hDEADBEEF);
    checkOutput("single_k1_pend5", 64'(pend_mask[5]), 64'd1);
    tick();
    checkOutput("single_k2_rw", 64'(rw), 64'd0);
    checkOutput("single_k2_pend", 64'(pend_mask), 64'd0);
    checkOutput("single_k2_idle", 64'(idle), 64'd1);

    $display("[TB] fairness");
    doReset();
    wlog.delete();
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 5'(i + 1), 32'hA000 + 32'(i + 1), 1'b1, 5'(i + 11), 32'hA000 + 32'(i + 11), 1'b0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    repeat (8) tick();
    checkOutput("fair_count", 64'(wlog.size()), 64'd8);
    for (int i = 0; i < 8 && i < wlog.size(); i++) begin
      checkOutput("fair_reg", 64'(wlog[i].r), 64'(exp_regs[i]));
      checkOutput("fair_data", 64'(wlog[i].d), 64'(32'hA000 + 32'(exp_regs[i])));
      checkOutput("fair_cycle", 64'(wlog[i].cyc - wlog[0].cyc), 64'(i));
    end
    checkOutput("fair_idle", 64'(idle), 64'd1);

    $display("[TB] full fifo backpressure");
    doReset();
    wlog.delete();
    n0 = 0; n1 = 0; saw_full = 1'b0;
    for (int c = 0; c < 30; c++) begin
      applyStimulus(1'b1, 5'(1 + n0 % 15), 32'(n0), 1'b1, 5'(16 + n1 % 15), 32'h100 + 32'(n1), 1'b0);
      if (m_acc0) n0++;
      if (m_acc1) n1++;
      if (!req1_ready) saw_full = 1'b1;
    end
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    repeat (15) tick();
    c0 = 0; c1 = 0;
    foreach (wlog[i]) if (wlog[i].r >= 5'd16) c1++; else c0++;
    checkOutput("full_seen", 64'(saw_full), 64'd1);
    checkOutput("full_resumed", 64'(req1_ready), 64'd1);
    checkOutput("full_src0_count", 64'(c0), 64'(n0));
    checkOutput("full_src1_count", 64'(c1), 64'(n1));

    $display("[TB] zero register");
    doReset();
    req0_valid = 1'b1; req0_addr = 5'd0; req0_data = 32'h1234;
    #1;
    checkOutput("zero_ready", 64'(req0_ready), 64'd1);
    tick();
    req0_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput("zero_rw", 64'(rw), 64'd0);
      checkOutput("zero_idle", 64'(idle), 64'd1);
      tick();
    end

    $display("[TB] reset mid traffic");
    doReset();
    for (int i = 0; i < 2; i++)
      applyStimulus(1'b1, 5'(i + 1), 32'(i), 1'b1, 5'(i + 21), 32'(i), 1'b0);
    req0_valid = 1'b0; req1_valid = 1'b0; rst = 1'b1;
    #1;
    checkOutput("midrst_ready0", 64'(req0_ready), 64'd0);
    checkOutput("midrst_ready1", 64'(req1_ready), 64'd0);
    tick();
    rst = 1'b0;
    wlog.delete();
    for (int i = 0; i < 4; i++) begin
      checkOutput("midrst_rw", 64'(rw), 64'd0);
      checkOutput("midrst_idle", 64'(idle), 64'd1);
      checkOutput("midrst_pend", 64'(pend_mask), 64'd0);
      tick();
    end
    checkOutput("midrst_no_writes", 64'(wlog.size()), 64'd0);

    $display("[TB] random traffic");
    doReset();
    wlog.delete();
    n_enq = 0;
    v0 = 1'b0; v1 = 1'b0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    for (int n = 0; n < 10000; n++) begin
      if (!v0) begin
        v0 = ($urandom_range(0, 3) != 0);
        a0 = pickAddr(0, v1, a1);
        d0 = $urandom;
      end
      if (!v1) begin
        v1 = ($urandom_range(0, 3) != 0);
        a1 = pickAddr(1, v0, a0);
        d1 = $urandom;
      end
      applyStimulus(v0, a0, d0, v1, a1, d1, 1'b0);
      if (m_acc0) begin v0 = 1'b0; if (a0 != 5'd0) n_enq++; end
      if (m_acc1) begin v1 = 1'b0; if (a1 != 5'd0) n_enq++; end
    end
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    repeat (20) tick();
    checkOutput("rand_idle", 64'(idle), 64'd1);
    checkOutput("rand_commit_count", 64'(wlog.size()), 64'(n_enq));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
